// File: rtl/motor_input_cond.sv
// motor_input_cond: sync/debounce of button and limit switches, activate pulse, limit fault; optional lockout via MOTOR_INPUT_COND_LOCKOUT_EN
module motor_input_cond #(
  parameter int DEB_CYCLES = 1000,
  parameter int CNT_W = 10,
  parameter int RAW_ACTIVE_LOW = 1,
  parameter int LOCKOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic dn_sw_raw,
  input  logic up_sw_raw,
  output logic activate,
  output logic dn_limit,
  output logic up_limit,
  output logic btn_level,
  output logic limit_fault
);
  localparam logic [2:0] INV = (RAW_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
  if (DEB_CYCLES < 2 || DEB_CYCLES > (1 << CNT_W) - 1) begin : g_bad_cnt_w
    $error("CNT_W too small for DEB_CYCLES");
  end
  logic [2:0] raw, meta, s, d;
  logic [CNT_W-1:0] c [3];
  logic btn_prev, rise, fire;
  assign raw = {up_sw_raw, dn_sw_raw, btn_raw} ^ INV;
  assign btn_level = d[0];
  assign dn_limit = d[1];
  assign up_limit = d[2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta <= '0;
      s <= '0;
      d <= '0;
      for (int k = 0; k < 3; k++) c[k] <= '0;
    end else begin
      meta <= raw;
      s <= meta;
      for (int k = 0; k < 3; k++)
        if (s[k] == d[k]) c[k] <= '0;
        else if (c[k] == LAST) begin
          d[k] <= s[k];
          c[k] <= '0;
        end else c[k] <= c[k] + 1'b1;
    end
  // an edge coinciding with the fault being registered is also dropped
  assign rise = d[0] & ~btn_prev & ~limit_fault & ~(d[1] & d[2]);
`ifdef MOTOR_INPUT_COND_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 2);
  logic [LW-1:0] lock;
  assign fire = rise & (lock == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lock <= '0;
    else lock <= fire ? LW'(LOCKOUT_CYCLES) : (lock != '0 ? lock - 1'b1 : lock);
`else
  assign fire = rise;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      btn_prev <= 1'b0;
      activate <= 1'b0;
      limit_fault <= 1'b0;
    end else begin
      btn_prev <= d[0];
      activate <= fire;
      limit_fault <= d[1] & d[2];
    end
endmodule

// File: tb/tb_motor_input_cond.sv
// tb_motor_input_cond: directed checks of debounce latency, glitch rejection, fault gating, async reset, lockout
module tb_motor_input_cond;
  logic clk, rst_n, btn_raw, dn_sw_raw, up_sw_raw;
  logic activate, dn_limit, up_limit, btn_level, limit_fault;
  logic [4:0] outs;
  int total, passed, pulses, p0;
  logic seen_btn, seen_up;
`ifdef MOTOR_INPUT_COND_LOCKOUT_EN
  localparam int LK = 1;
`else
  localparam int LK = 0;
`endif
  motor_input_cond #(
    .DEB_CYCLES(4),
    .CNT_W(3),
    .RAW_ACTIVE_LOW(1),
    .LOCKOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .dn_sw_raw(dn_sw_raw),
    .up_sw_raw(up_sw_raw),
    .activate(activate),
    .dn_limit(dn_limit),
    .up_limit(up_limit),
    .btn_level(btn_level),
    .limit_fault(limit_fault)
  );
  assign outs = {activate, dn_limit, up_limit, btn_level, limit_fault};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else passed++;
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pulses += int'(activate);
      seen_btn |= btn_level;
      seen_up |= up_limit;
    end
  endtask
  initial begin
    total = 0; passed = 0; pulses = 0;
    seen_btn = 1'b0; seen_up = 1'b0;
    rst_n = 1'b0; btn_raw = 1'b1; dn_sw_raw = 1'b1; up_sw_raw = 1'b1;
    cyc(3);
    chk("rst_outs", int'(outs), 0);
    rst_n = 1'b1;
    cyc(20);
    chk("idle_outs", int'(outs), 0);
    chk("idle_pulses", pulses, 0);
    chk("idle_seen", int'(seen_btn | seen_up), 0);
    p0 = pulses;
    btn_raw = 1'b0;
    cyc(5);
    chk("press_lvl_pre", int'(btn_level), 0);
    cyc(1);
    chk("press_lvl_rise", int'(btn_level), 1);
    chk("press_act_early", int'(activate), 0);
    cyc(1);
    chk("press_act_pulse", int'(activate), 1);
    cyc(1);
    chk("press_act_once", int'(activate), 0);
    cyc(10);
    chk("held_pulses", pulses - p0, 1);
    btn_raw = 1'b1;
    cyc(5);
    chk("rel_lvl_hold", int'(btn_level), 1);
    cyc(1);
    chk("rel_lvl_fall", int'(btn_level), 0);
    cyc(5);
    chk("rel_pulses", pulses - p0, 1);
    p0 = pulses; seen_btn = 1'b0;
    btn_raw = 1'b0; cyc(3); btn_raw = 1'b1; cyc(1); btn_raw = 1'b0; cyc(3); btn_raw = 1'b1;
    cyc(10);
    chk("glitch_btn_lvl", int'(seen_btn), 0);
    chk("glitch_btn_pulses", pulses - p0, 0);
    seen_up = 1'b0;
    up_sw_raw = 1'b0; cyc(3); up_sw_raw = 1'b1; cyc(1); up_sw_raw = 1'b0; cyc(3); up_sw_raw = 1'b1;
    cyc(10);
    chk("glitch_up_lvl", int'(seen_up), 0);
    p0 = pulses;
    btn_raw = 1'b0; dn_sw_raw = 1'b0; up_sw_raw = 1'b0;
    cyc(6);
    chk("lim_both", int'({dn_limit, up_limit, limit_fault}), 3'b110);
    cyc(1);
    chk("fault_set", int'(limit_fault), 1);
    chk("same_edge_pulses", pulses - p0, 0);
    btn_raw = 1'b1;
    cyc(8);
    chk("fault_btn_rel", int'(btn_level), 0);
    btn_raw = 1'b0;
    cyc(10);
    chk("fault_press_lvl", int'(btn_level), 1);
    chk("fault_press_pulses", pulses - p0, 0);
    up_sw_raw = 1'b1;
    cyc(6);
    chk("up_fall", int'({up_limit, limit_fault}), 2'b01);
    cyc(1);
    chk("fault_clr", int'(limit_fault), 0);
    cyc(5);
    chk("no_replay", pulses - p0, 0);
    btn_raw = 1'b1;
    cyc(8);
    btn_raw = 1'b0;
    cyc(7);
    chk("new_press_act", int'(activate), 1);
    chk("new_press_pulses", pulses - p0, 1);
    btn_raw = 1'b1;
    cyc(8);
    chk("dn_still_high", int'(dn_limit), 1);
    p0 = pulses;
    btn_raw = 1'b0;
    cyc(4);
    #2 rst_n = 1'b0;
    #1 chk("async_clr", int'(outs), 0);
    dn_sw_raw = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk("rst_lvl_pre", int'(btn_level), 0);
    chk("rst_no_early", pulses - p0, 0);
    cyc(1);
    chk("rst_lvl_rise", int'(btn_level), 1);
    cyc(1);
    chk("rst_act", int'(activate), 1);
    chk("rst_pulses", pulses - p0, 1);
    btn_raw = 1'b1;
    cyc(8);
    p0 = pulses;
    btn_raw = 1'b0; cyc(7);
    chk("lk_first_act", int'(activate), 1);
    btn_raw = 1'b1; cyc(7);
    btn_raw = 1'b0; cyc(7);
    btn_raw = 1'b1; cyc(7);
    chk("lk_second", pulses - p0, 2 - LK);
    cyc(9);
    btn_raw = 1'b0; cyc(7);
    chk("lk_third_act", int'(activate), 1);
    chk("lk_third", pulses - p0, 3 - LK);
    btn_raw = 1'b1;
    cyc(8);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
